// File: rtl/regfile_writeback_pkg.sv
// -----------------------------------------------------------------------------
// regfile_writeback_pkg
//   Shared widths and types for the register-file write-back path.
//   XLEN / REG_AW / REG_COUNT match the integer register file (32 x 32 bit).
//   wb_entry_t is the buffered load result (destination + data).
//   win_src_t names the source that owns the write port in a given cycle.
// -----------------------------------------------------------------------------
package regfile_writeback_pkg;

   localparam int XLEN       = 32;
   localparam int REG_AW     = 5;
   localparam int REG_COUNT  = 32;
   localparam int LD_ENTRY_W = REG_AW + XLEN;

   typedef struct packed {
      logic [REG_AW-1:0] rd;
      logic [XLEN-1:0]   data;
   } wb_entry_t;

   typedef enum logic [1:0] {
      WIN_NONE = 2'd0,
      WIN_ALU  = 2'd1,
      WIN_LOAD = 2'd2
   } win_src_t;

   // x0 is hard-wired to zero: writes to it are consumed but never performed.
   function automatic logic is_x0(input logic [REG_AW-1:0] rd);
      return (rd == '0);
   endfunction

endpackage

// File: rtl/regfile_writeback_if.sv
// -----------------------------------------------------------------------------
// regfile_writeback_if
//   Bundles every non-clock signal of the write-back controller.
//   slave  : the controller (regfile_writeback)
//   master : the surrounding pipeline / register file (or a testbench)
//
//   Handshakes:
//     ALU  : a result transfers on a cycle where alu_valid & alu_ready. While
//            alu_valid is high and alu_ready low, the producer holds alu_rd and
//            alu_data stable. alu_ready is combinational and may drop only on a
//            cycle where a buffered load is forced through.
//     Load : a result transfers on ld_valid & ld_ready; ld_ready comes from
//            registered FIFO state only. A load offered while ld_ready is low
//            is not taken.
//     issue_en/issue_rd and query_a/query_b carry no handshake.
//     wb_en/wb_addr/wb_data are a registered one-cycle write strobe.
// -----------------------------------------------------------------------------
interface regfile_writeback_if;
   import regfile_writeback_pkg::*;

   logic              alu_valid;
   logic [REG_AW-1:0] alu_rd;
   logic [XLEN-1:0]   alu_data;
   logic              alu_ready;

   logic              ld_valid;
   logic [REG_AW-1:0] ld_rd;
   logic [XLEN-1:0]   ld_data;
   logic              ld_ready;

   logic              issue_en;
   logic [REG_AW-1:0] issue_rd;

   logic [REG_AW-1:0] query_a;
   logic [REG_AW-1:0] query_b;
   logic              busy_a;
   logic              busy_b;

   logic              wb_en;
   logic [REG_AW-1:0] wb_addr;
   logic [XLEN-1:0]   wb_data;

   modport slave (
      input  alu_valid, alu_rd, alu_data,
      output alu_ready,
      input  ld_valid, ld_rd, ld_data,
      output ld_ready,
      input  issue_en, issue_rd,
      input  query_a, query_b,
      output busy_a, busy_b,
      output wb_en, wb_addr, wb_data
   );

   modport master (
      output alu_valid, alu_rd, alu_data,
      input  alu_ready,
      output ld_valid, ld_rd, ld_data,
      input  ld_ready,
      output issue_en, issue_rd,
      output query_a, query_b,
      input  busy_a, busy_b,
      input  wb_en, wb_addr, wb_data
   );

endinterface

// File: rtl/regfile_writeback_wb_fifo.sv
// -----------------------------------------------------------------------------
// wb_fifo
//   Small synchronous FIFO holding load results until they win the write port.
//   Ports:
//     clk, rst_n  : clock, asynchronous active-low reset (empties the FIFO)
//     i_push      : write i_data this cycle (caller guarantees !o_full)
//     i_data      : entry to write
//     i_pop       : drop the head this cycle (caller guarantees !o_empty)
//     o_data      : current head entry (combinational read of storage)
//     o_full      : DEPTH entries held
//     o_empty     : no entries held
//   Pointers carry one extra wrap bit so full and empty are distinguishable
//   when the index parts are equal.
// -----------------------------------------------------------------------------
module wb_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 37
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_push,
   input  logic [W-1:0] i_data,
   input  logic         i_pop,
   output logic [W-1:0] o_data,
   output logic         o_full,
   output logic         o_empty
);

   localparam int          AW      = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   logic [W-1:0] r_mem [DEPTH];
   logic [AW:0]  r_wr_ptr;
   logic [AW:0]  r_rd_ptr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (i_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
         if (i_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
   end

   // Storage needs no reset: an entry is only read after it has been written.
   always_ff @(posedge clk) begin
      if (i_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
   end

   assign o_data  = r_mem[r_rd_ptr[AW-1:0]];
   assign o_empty = (r_wr_ptr == r_rd_ptr);
   assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                    (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

endmodule

// File: rtl/regfile_writeback.sv
// -----------------------------------------------------------------------------
// regfile_writeback
//   Write-side controller for the 32 x 32 integer register file. Merges
//   single-cycle ALU results and buffered multi-cycle load results onto the
//   file's single write port, drops x0 writes, and keeps a busy scoreboard of
//   outstanding loads for decode's RAW interlock.
//   Ports:
//     clk     : system clock, all state on the rising edge
//     rst_n   : asynchronous active-low reset
//     wb_bus  : regfile_writeback_if.slave
//               alu_valid/alu_rd/alu_data -> alu_ready   (ALU results)
//               ld_valid/ld_rd/ld_data    -> ld_ready    (load results)
//               issue_en/issue_rd                       (mark load dest busy)
//               query_a/query_b           -> busy_a/busy_b
//               wb_en/wb_addr/wb_data                   (registered write)
//   Parameters:
//     LD_DEPTH   : load FIFO entries (power of two, >= 2)
//     STARVE_MAX : consecutive ALU wins tolerated while loads wait
// -----------------------------------------------------------------------------
module regfile_writeback
   import regfile_writeback_pkg::*;
#(
   parameter int LD_DEPTH   = 4,
   parameter int STARVE_MAX = 3
) (
   input  logic                 clk,
   input  logic                 rst_n,
   regfile_writeback_if.slave   wb_bus
);

   localparam int SC_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
   localparam logic [SC_W-1:0] STARVE_LIM = SC_W'(STARVE_MAX);
   localparam logic [SC_W-1:0] STARVE_ONE = SC_W'(1);

   // ---------------------------------------------------------------- FIFO
   wb_entry_t w_head;
   wb_entry_t w_push_entry;
   logic      w_fifo_full;
   logic      w_fifo_empty;
   logic      w_push;
   logic      w_pop;

   assign w_push_entry = '{rd: wb_bus.ld_rd, data: wb_bus.ld_data};

   wb_fifo #(
      .DEPTH (LD_DEPTH),
      .W     (LD_ENTRY_W)
   ) u_wb_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_push),
      .i_data  (w_push_entry),
      .i_pop   (w_pop),
      .o_data  (w_head),
      .o_full  (w_fifo_full),
      .o_empty (w_fifo_empty)
   );

   // ------------------------------------------------------------- arbiter
   logic [SC_W-1:0] r_starve;
   logic            w_force;
   logic            w_alu_win;
   logic            w_ld_win;
   win_src_t        w_win;

   // A force cycle hands the port to the FIFO head even if the ALU is valid,
   // bounding how long a waiting load can be starved.
   assign w_force   = !w_fifo_empty && (r_starve == STARVE_LIM);
   assign w_alu_win = wb_bus.alu_valid && !w_force;
   assign w_ld_win  = !w_fifo_empty && !w_alu_win;

   assign w_push = wb_bus.ld_valid && !w_fifo_full;
   assign w_pop  = w_ld_win;

   assign wb_bus.alu_ready = !w_force;
   assign wb_bus.ld_ready  = !w_fifo_full;

   always_comb begin
      w_win = WIN_NONE;
      if (w_alu_win)     w_win = WIN_ALU;
      else if (w_ld_win) w_win = WIN_LOAD;
   end

   // Counts ALU wins only while a load is waiting; any pop or an empty FIFO
   // restarts the window.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_starve <= '0;
      end else if (w_pop || w_fifo_empty) begin
         r_starve <= '0;
      end else if (w_alu_win) begin
         r_starve <= r_starve + STARVE_ONE;
      end
   end

   // ---------------------------------------------------------- scoreboard
   logic [REG_COUNT-1:0] r_busy;
   logic [REG_COUNT-1:0] w_busy_nxt;

   // Clear is applied before set so an issue to the same rd in the cycle its
   // older load retires leaves the register busy.
   always_comb begin
      w_busy_nxt = r_busy;
      if (w_ld_win) w_busy_nxt[w_head.rd] = 1'b0;
      if (wb_bus.issue_en && !is_x0(wb_bus.issue_rd))
         w_busy_nxt[wb_bus.issue_rd] = 1'b1;
      w_busy_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_busy <= '0;
      else        r_busy <= w_busy_nxt;
   end

   assign wb_bus.busy_a = !is_x0(wb_bus.query_a) && r_busy[wb_bus.query_a];
   assign wb_bus.busy_b = !is_x0(wb_bus.query_b) && r_busy[wb_bus.query_b];

   // ------------------------------------------------------- write port regs
   logic              r_wb_en;
   logic [REG_AW-1:0] r_wb_addr;
   logic [XLEN-1:0]   r_wb_data;
   logic              w_wr_en;
   logic [REG_AW-1:0] w_wr_addr;
   logic [XLEN-1:0]   w_wr_data;

   // A winner targeting x0 is consumed but produces no write; address and
   // data then keep their previous values.
   always_comb begin
      w_wr_en   = 1'b0;
      w_wr_addr = r_wb_addr;
      w_wr_data = r_wb_data;
      case (w_win)
         WIN_ALU: begin
            w_wr_en   = !is_x0(wb_bus.alu_rd);
            w_wr_addr = wb_bus.alu_rd;
            w_wr_data = wb_bus.alu_data;
         end
         WIN_LOAD: begin
            w_wr_en   = !is_x0(w_head.rd);
            w_wr_addr = w_head.rd;
            w_wr_data = w_head.data;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wb_en   <= 1'b0;
         r_wb_addr <= '0;
         r_wb_data <= '0;
      end else begin
         r_wb_en <= w_wr_en;
         if (w_wr_en) begin
            r_wb_addr <= w_wr_addr;
            r_wb_data <= w_wr_data;
         end
      end
   end

   assign wb_bus.wb_en   = r_wb_en;
   assign wb_bus.wb_addr = r_wb_addr;
   assign wb_bus.wb_data = r_wb_data;

endmodule

// File: tb/tb_regfile_writeback.sv
// -----------------------------------------------------------------------------
// tb_regfile_writeback
//   Drives regfile_writeback through directed scenarios and a random phase.
//   A reference model (load queue, starve count, busy bit array) predicts each
//   cycle's write; predictions go into exp_q and a monitor compares them to
//   the registered write port one edge later.
// -----------------------------------------------------------------------------
module tb_regfile_writeback;
   import regfile_writeback_pkg::*;

   localparam int LD_DEPTH   = 4;
   localparam int STARVE_MAX = 3;

   // ------------------------------------------------- clock / reset
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   regfile_writeback_if wb_if();

   regfile_writeback #(
      .LD_DEPTH   (LD_DEPTH),
      .STARVE_MAX (STARVE_MAX)
   ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .wb_bus (wb_if)
   );

   // ------------------------------------------------- scoreboard state
   int          checks = 0;
   int          errors = 0;
   logic [37:0] exp_q[$];          // {wb_en, wb_addr, wb_data}
   logic [37:0] mon_e;

   // reference model
   logic [36:0] m_q[$];            // {rd, data} loads waiting
   int          m_starve = 0;
   logic [31:0] m_sb     = '0;
   logic        m_ready  = 1'b1;   // model's alu_ready for the last step

   logic        dut_alu_ready;
   logic        dut_ld_ready;
   logic        dut_busy_a;

   task automatic chk(input string name, input logic [37:0] act, input logic [37:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // ------------------------------------------------- driver + model
   // Called at a falling edge; returns at the next falling edge.
   task automatic step(input logic av, input logic [4:0] ard, input logic [31:0] adat,
                       input logic lv, input logic [4:0] lrd, input logic [31:0] ldat,
                       input logic ie, input logic [4:0] ird,
                       input logic [4:0] qa, input logic [4:0] qb);
      logic        force_c;
      logic        alu_win;
      logic        ld_win;
      int          n_before;
      logic [36:0] h;
      logic [37:0] e;
      wb_if.alu_valid = av;  wb_if.alu_rd = ard;  wb_if.alu_data = adat;
      wb_if.ld_valid  = lv;  wb_if.ld_rd  = lrd;  wb_if.ld_data  = ldat;
      wb_if.issue_en  = ie;  wb_if.issue_rd = ird;
      wb_if.query_a   = qa;  wb_if.query_b  = qb;
      #1;
      dut_alu_ready = wb_if.alu_ready;
      dut_ld_ready  = wb_if.ld_ready;
      dut_busy_a    = wb_if.busy_a;

      n_before = m_q.size();
      force_c  = (n_before != 0) && (m_starve == STARVE_MAX);
      chk("alu_ready", wb_if.alu_ready, !force_c);
      chk("ld_ready", wb_if.ld_ready, n_before < LD_DEPTH);
      chk("busy_a", wb_if.busy_a, (qa != 5'd0) && m_sb[qa]);
      chk("busy_b", wb_if.busy_b, (qb != 5'd0) && m_sb[qb]);

      alu_win = av && !force_c;
      ld_win  = !alu_win && (n_before != 0);
      e = '0;
      h = '0;
      if (alu_win) begin
         e = {ard != 5'd0, ard, adat};
      end else if (ld_win) begin
         h = m_q[0];
         e = {h[36:32] != 5'd0, h};
      end
      exp_q.push_back(e);

      if (ld_win) void'(m_q.pop_front());
      if (lv && n_before < LD_DEPTH) m_q.push_back({lrd, ldat});

      if (ld_win || n_before == 0) m_starve = 0;
      else if (alu_win)            m_starve++;

      if (ld_win) m_sb[h[36:32]] = 1'b0;
      if (ie && ird != 5'd0) m_sb[ird] = 1'b1;

      m_ready = !force_c;
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++)
         step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0,
              5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
   endtask

   task automatic drain();
      for (int k = 0; k < 40 && m_q.size() != 0; k++) idle(1);
      idle(2);
      chk("drain_model_q", 38'(m_q.size()), 38'd0);
   endtask

   // ------------------------------------------------- monitor
   always @(posedge clk) begin
      #1;
      if (rst_n) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL wb_no_expectation actual=%b expected=entry", wb_if.wb_en);
         end else begin
            mon_e = exp_q.pop_front();
            chk("wb_en", wb_if.wb_en, mon_e[37]);
            if (mon_e[37]) chk("wb_write", {1'b0, wb_if.wb_addr, wb_if.wb_data}, {1'b0, mon_e[36:0]});
         end
      end
   end

   // ------------------------------------------------- stimulus
   logic [4:0]  seq;
   logic [31:0] a_dat;
   logic        av_r;
   logic [4:0]  ard_r;
   logic [31:0] adat_r;

   initial begin
      wb_if.alu_valid = 1'b0; wb_if.alu_rd = '0; wb_if.alu_data = '0;
      wb_if.ld_valid  = 1'b0; wb_if.ld_rd  = '0; wb_if.ld_data  = '0;
      wb_if.issue_en  = 1'b0; wb_if.issue_rd = '0;
      wb_if.query_a   = 5'd7; wb_if.query_b  = 5'd3;
      #1;
      chk("rst_wb_en", wb_if.wb_en, 1'b0);
      chk("rst_wb_addr", wb_if.wb_addr, 5'd0);
      chk("rst_wb_data", wb_if.wb_data, 32'd0);
      chk("rst_ld_ready", wb_if.ld_ready, 1'b1);
      chk("rst_alu_ready", wb_if.alu_ready, 1'b1);
      chk("rst_busy", {wb_if.busy_a, wb_if.busy_b}, 2'b00);
      @(negedge clk);
      rst_n = 1'b1;

      // ALU only
      step(1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd5, 5'd0);
      idle(2);

      // x0 drop
      step(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);
      chk("x0_alu_ready", dut_alu_ready, 1'b1);
      idle(2);

      // load path with scoreboard
      step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 5'd7, 5'd0);
      step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd7, 5'd0);
      chk("busy7_after_issue", dut_busy_a, 1'b1);
      step(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'hA5A5_0000, 1'b0, 5'd0, 5'd7, 5'd0);
      for (int k = 0; k < 4; k++)
         step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd7, 5'd7);
      chk("busy7_after_retire", dut_busy_a, 1'b0);

      // starvation: one waiting load, ALU held valid
      step(1'b0, 5'd0, 32'd0, 1'b1, 5'd8, 32'h8888_0008, 1'b1, 5'd8, 5'd8, 5'd9);
      a_dat = 32'h9000_0000;
      for (int k = 0; k < 5; k++) begin
         step(1'b1, 5'd9, a_dat, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd8, 5'd9);
         seq[k] = dut_alu_ready;
         if (m_ready) a_dat = a_dat + 32'd1;
      end
      chk("starve_ready_seq", seq, 5'b10111);
      idle(2);

      // full FIFO: four pushes with ALU held valid
      a_dat = 32'hB000_0000;
      for (int k = 0; k < 4; k++) begin
         step(1'b1, 5'd11, a_dat, 1'b1, 5'(12 + k), 32'hC000_0000 + 32'(k),
              1'b1, 5'(12 + k), 5'(12 + k), 5'd11);
         if (m_ready) a_dat = a_dat + 32'd1;
      end
      step(1'b1, 5'd11, a_dat, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd12, 5'd15);
      chk("full_ld_ready", dut_ld_ready, 1'b0);
      if (m_ready) a_dat = a_dat + 32'd1;
      for (int k = 0; k < 16; k++) begin
         step(1'b1, 5'd11, a_dat, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd13, 5'd15);
         if (m_ready) a_dat = a_dat + 32'd1;
      end
      drain();

      // random phase (ALU inputs held while stalled)
      av_r = 1'b0; ard_r = '0; adat_r = '0;
      for (int i = 0; i < 400; i++) begin
         if (!(av_r && !m_ready)) begin
            av_r   = ($urandom_range(0, 3) != 0);
            ard_r  = 5'($urandom_range(0, 31));
            adat_r = $urandom;
         end
         step(av_r, ard_r, adat_r,
              $urandom_range(0, 2) == 0, 5'($urandom_range(0, 31)), $urandom,
              $urandom_range(0, 3) == 0, 5'($urandom_range(0, 31)),
              5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      end
      drain();

      // async reset mid-burst
      step(1'b1, 5'd3, 32'h3333_0003, 1'b1, 5'd20, 32'h2020_2020, 1'b1, 5'd20, 5'd20, 5'd21);
      step(1'b1, 5'd4, 32'h4444_0004, 1'b1, 5'd21, 32'h2121_2121, 1'b1, 5'd21, 5'd20, 5'd21);
      chk("pre_reset_wb_en", wb_if.wb_en, 1'b1);
      chk("pre_reset_busy", {wb_if.busy_a, wb_if.busy_b}, 2'b11);
      rst_n = 1'b0;
      wb_if.alu_valid = 1'b0; wb_if.ld_valid = 1'b0; wb_if.issue_en = 1'b0;
      #1;
      chk("mid_rst_wb_en", wb_if.wb_en, 1'b0);
      chk("mid_rst_wb_addr", wb_if.wb_addr, 5'd0);
      chk("mid_rst_wb_data", wb_if.wb_data, 32'd0);
      chk("mid_rst_busy", {wb_if.busy_a, wb_if.busy_b}, 2'b00);
      chk("mid_rst_ld_ready", wb_if.ld_ready, 1'b1);
      m_q.delete();
      exp_q.delete();
      m_starve = 0;
      m_sb     = '0;
      m_ready  = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 5; k++)
         step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd20, 5'd21);

      chk("exp_q_empty", 38'(exp_q.size()), 38'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
